// File: rtl/aes_pkg.sv
// Shared constants and types for the AES input staging logic.
package aes_pkg;

  localparam int AES_BLOCK_W       = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = 4;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_EMIT    = 2'd2
  } ld_state_e;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_KEY  = 1'b1;

  function automatic logic [AES_WORD_W-1:0] bswap32(input logic [AES_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// Word counter and 128-bit assembly register; AES_LOADER_BSWAP_EN byte-reverses
// each accepted word for little-endian hosts.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   word_accept,
  input  logic                   restart,
  input  logic                   clear,
  input  logic [AES_WORD_W-1:0]  word_in,
  output logic [AES_BLOCK_W-1:0] asm_blk,
  output logic                   blk_done
);

  logic [1:0]             count_q, count_d;
  logic [AES_BLOCK_W-1:0] asm_q, asm_d;
  logic [AES_WORD_W-1:0]  word_sw;

`ifdef AES_LOADER_BSWAP_EN
  assign word_sw = bswap32(word_in);
`else
  assign word_sw = word_in;
`endif

  always_comb begin
    count_d  = count_q;
    asm_d    = asm_q;
    blk_done = 1'b0;
    if (clear) begin
      count_d = 2'd0;
    end else if (word_accept) begin
      if (restart) begin
        // Type mismatch: this word opens a fresh block.
        asm_d   = {word_sw, {(AES_BLOCK_W-AES_WORD_W){1'b0}}};
        count_d = 2'd1;
      end else begin
        for (int k = 0; k < AES_WORDS_PER_BLK; k++) begin
          if (count_q == 2'(k))
            asm_d[AES_BLOCK_W-1-AES_WORD_W*k -: AES_WORD_W] = word_sw;
        end
        count_d  = count_q + 2'd1;
        blk_done = (count_q == 2'd3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      asm_q   <= '0;
    end else begin
      count_q <= count_d;
      asm_q   <= asm_d;
    end
  end

  assign asm_blk = asm_q;

endmodule

// File: rtl/aes_block_loader.sv
// Stages a tagged 32-bit word stream into 128-bit plaintext/key blocks for the
// AES pipeline. Optional byte swap via AES_LOADER_BSWAP_EN (see aes_word_packer).
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   in_word,
  input  logic                    in_sel,
  input  logic                    flush,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic [BLOCK_LENGTH-1:0] KEY,
  output logic                    next_round_enable,
  output logic                    key_valid,
  output logic                    err
);

  ld_state_e              state_q, state_d;
  logic                   blk_sel_q, blk_sel_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [AES_BLOCK_W-1:0] out_q, out_d;
  logic                   key_valid_q, key_valid_d;
  logic                   nre_q, nre_d;
  logic                   err_q, err_d;

  logic                   accept, mismatch, pk_clear, blk_done;
  logic [AES_BLOCK_W-1:0] asm_blk;

  // EMIT is the one-cycle bubble per block.
  assign in_ready = !rst && (state_q != LD_EMIT);
  assign accept   = in_valid && in_ready && !flush;
  assign mismatch = accept && (state_q == LD_COLLECT) && (in_sel != blk_sel_q);
  assign pk_clear = flush && (state_q != LD_EMIT);

  aes_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .word_accept (accept),
    .restart     (mismatch),
    .clear       (pk_clear),
    .word_in     (in_word),
    .asm_blk     (asm_blk),
    .blk_done    (blk_done)
  );

  always_comb begin
    state_d     = state_q;
    blk_sel_d   = blk_sel_q;
    key_d       = key_q;
    out_d       = out_q;
    key_valid_d = key_valid_q;
    nre_d       = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (accept) begin
          blk_sel_d = in_sel;
          state_d   = LD_COLLECT;
        end
      end
      LD_COLLECT: begin
        if (flush) begin
          state_d = LD_IDLE;
        end else if (mismatch) begin
          err_d     = 1'b1;
          blk_sel_d = in_sel;
        end else if (blk_done) begin
          state_d = LD_EMIT;
        end
      end
      LD_EMIT: begin
        // Not interruptible by flush: the completed block always commits.
        state_d = LD_IDLE;
        if (blk_sel_q == SEL_KEY) begin
          key_d       = asm_blk;
          key_valid_d = 1'b1;
        end else if (key_valid_q) begin
          out_d = asm_blk;
          nre_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      blk_sel_q   <= SEL_DATA;
      key_q       <= '0;
      out_q       <= '0;
      key_valid_q <= 1'b0;
      nre_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_sel_q   <= blk_sel_d;
      key_q       <= key_d;
      out_q       <= out_d;
      key_valid_q <= key_valid_d;
      nre_q       <= nre_d;
      err_q       <= err_d;
    end
  end

  assign OUT               = out_q;
  assign KEY               = key_q;
  assign key_valid         = key_valid_q;
  assign next_round_enable = nre_q;
  assign err               = err_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader; honours AES_LOADER_BSWAP_EN.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_sel, flush;
  logic [31:0]  in_word;
  logic [127:0] OUT, KEY;
  logic         next_round_enable, key_valid, err;

  always #5 clk = ~clk;

  aes_block_loader dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_word           (in_word),
    .in_sel            (in_sel),
    .flush             (flush),
    .OUT               (OUT),
    .KEY               (KEY),
    .next_round_enable (next_round_enable),
    .key_valid         (key_valid),
    .err               (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int nre_cnt  = 0;
  int rdy_low  = 0;
  int nre_prev = 0;
  int nre_last = 0;
  int acc_cyc  = 0;
  bit b2b_on   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err) err_cnt <= err_cnt + 1;
    if (next_round_enable) begin
      nre_cnt  <= nre_cnt + 1;
      nre_prev <= nre_last;
      nre_last <= cyc;
    end
    if (b2b_on && !in_ready) rdy_low <= rdy_low + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_LOADER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] exp_blk(input logic [127:0] b);
    return {sw(b[127:96]), sw(b[95:64]), sw(b[63:32]), sw(b[31:0])};
  endfunction

  // Presents one word and returns just after the posedge that accepts it.
  task automatic push(input logic sel, input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = sel;
    in_word  = w;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("ready_timeout", 128'(n), 128'(0));
    acc_cyc = cyc;
    @(posedge clk);
    $display("push sel=%0d word=%h accepted in cycle %0d", sel, w, acc_cyc);
  endtask

  task automatic push4(input logic sel, input logic [127:0] b);
    push(sel, b[127:96]);
    push(sel, b[95:64]);
    push(sel, b[63:32]);
    push(sel, b[31:0]);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [127:0] KEY_BLK = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] PT_BLK  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] MM_KEY  = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
  localparam logic [127:0] FR_BLK  = 128'h01020304_05060708_090a0b0c_0d0e0f10;

  logic [127:0] b2b_blk [3];
  logic [31:0]  exp_msw;
  int e0, n0, r0, a0;

  initial begin
    b2b_blk[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    b2b_blk[1] = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    b2b_blk[2] = 128'h13579bdf_2468ace0_fedcba98_76543210;
`ifdef AES_LOADER_BSWAP_EN
    exp_msw = 32'h04030201;
`else
    exp_msw = 32'h01020304;
`endif
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; flush = 1'b0; in_word = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out", OUT, '0);
    check_eq("rst_key", KEY, '0);
    check_eq("rst_flags", {next_round_enable, key_valid, err}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Data before any key: dropped with an error
    e0 = err_cnt; n0 = nre_cnt;
    push4(1'b0, PT_BLK);
    idle(4);
    check_eq("nokey_err", 128'(err_cnt - e0), 128'(1));
    check_eq("nokey_nre", 128'(nre_cnt - n0), 128'(0));
    check_eq("nokey_out", OUT, '0);
    check_eq("nokey_kv", key_valid, 1'b0);

    // Key then data
    e0 = err_cnt; n0 = nre_cnt;
    push4(1'b1, KEY_BLK);
    idle(3);
    check_eq("key_val", KEY, exp_blk(KEY_BLK));
    check_eq("key_kv", key_valid, 1'b1);
    check_eq("key_nre", 128'(nre_cnt - n0), 128'(0));
    push4(1'b0, PT_BLK);
    a0 = acc_cyc;
    idle(4);
    check_eq("pt_out", OUT, exp_blk(PT_BLK));
    check_eq("pt_nre", 128'(nre_cnt - n0), 128'(1));
    check_eq("pt_latency", 128'(nre_last - a0), 128'(2));
    check_eq("pt_err", 128'(err_cnt - e0), 128'(0));
    check_eq("pt_nre_low", next_round_enable, 1'b0);

    // Type mismatch: two data words then a key block
    e0 = err_cnt; n0 = nre_cnt;
    push(1'b0, 32'h11111111);
    push(1'b0, 32'h22222222);
    push4(1'b1, MM_KEY);
    idle(4);
    check_eq("mm_err", 128'(err_cnt - e0), 128'(1));
    check_eq("mm_key", KEY, exp_blk(MM_KEY));
    check_eq("mm_nre", 128'(nre_cnt - n0), 128'(0));
    check_eq("mm_out_hold", OUT, exp_blk(PT_BLK));

    // Back-to-back data blocks with in_valid held
    e0 = err_cnt; n0 = nre_cnt; r0 = rdy_low;
    b2b_on = 1'b1;
    for (int i = 0; i < 3; i++) push4(1'b0, b2b_blk[i]);
    idle(4);
    b2b_on = 1'b0;
    @(negedge clk);
    check_eq("b2b_ready_low", 128'(rdy_low - r0), 128'(3));
    check_eq("b2b_nre", 128'(nre_cnt - n0), 128'(3));
    check_eq("b2b_spacing", 128'(nre_last - nre_prev), 128'(5));
    check_eq("b2b_out", OUT, exp_blk(b2b_blk[2]));
    check_eq("b2b_err", 128'(err_cnt - e0), 128'(0));

    // Flush after 3 words, then a fresh block
    e0 = err_cnt; n0 = nre_cnt;
    push(1'b0, 32'hffffffff);
    push(1'b0, 32'heeeeeeee);
    push(1'b0, 32'hdddddddd);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push4(1'b0, FR_BLK);
    idle(4);
    check_eq("flush_out", OUT, exp_blk(FR_BLK));
    check_eq("flush_msw", OUT[127:96], exp_msw);
    check_eq("flush_err", 128'(err_cnt - e0), 128'(0));
    check_eq("flush_nre", 128'(nre_cnt - n0), 128'(1));

    // Reset after 2 words
    push(1'b0, 32'h12345678);
    push(1'b0, 32'h9abcdef0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_in_ready", in_ready, 1'b0);
    check_eq("midrst_out", OUT, '0);
    check_eq("midrst_key", KEY, '0);
    check_eq("midrst_flags", {next_round_enable, key_valid, err}, 3'b000);
    rst = 1'b0;
    e0 = err_cnt; n0 = nre_cnt;
    push4(1'b0, PT_BLK);
    idle(4);
    check_eq("midrst_rekey_err", 128'(err_cnt - e0), 128'(1));
    check_eq("midrst_rekey_nre", 128'(nre_cnt - n0), 128'(0));
    check_eq("midrst_rekey_out", OUT, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Input staging block directly upstream of the encryption pipeline's initial key-add stage.
- Accepts a 32-bit word stream with a valid/ready handshake. Each word is tagged as plaintext or key.
- Assembles the words into 128-bit blocks and keeps the current cipher key in a register.
- For each complete plaintext block, drives the pipeline's 128-bit data input, key input and one-cycle enable.

Parameters:
- BLOCK_LENGTH, 128, width of a data/key block; only 128 is supported.
- WORD_WIDTH, 32, width of an input word; BLOCK_LENGTH/WORD_WIDTH = 4 words per block.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word present on in_word.
- in_ready  out  1  loader accepts the word this cycle.
- in_word  in  WORD_WIDTH  input word; the first word of a block is the most significant.
- in_sel  in  1  0 = plaintext word, 1 = key word; qualified by in_valid.
- flush  in  1  discards the partial block; has priority over a same-cycle word.
- OUT  out  BLOCK_LENGTH  assembled plaintext block, feeds the pipeline data input.
- KEY  out  BLOCK_LENGTH  current cipher key, feeds the pipeline key input.
- next_round_enable  out  1  one-cycle pulse, OUT valid; feeds the pipeline enable.
- key_valid  out  1  sticky; a full key has been loaded since reset.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (rst=1 at posedge): all of the following are 0 after the edge: OUT, KEY, next_round_enable, key_valid, err, word count, assembly register. The FSM goes to IDLE and in_ready is 0 during the reset cycle.
- FSM states:
  - IDLE: count=0, no block in progress.
  - COLLECT: 1 to 3 words held; block type latched in blk_sel.
  - EMIT: single cycle, commits the assembled block.
- Accept: a word is accepted when in_valid & in_ready & !flush.
  - in_ready = !rst & (state != EMIT), so one bubble occurs per block.
  - Peak throughput is 1 block per 5 cycles.
- Assembly:
  - Word k (k = 0..3) goes to asm[127-32k : 96-32k].
  - The count increments per accepted word.
- Block type:
  - The first word's in_sel is latched into blk_sel.
  - A later word with in_sel != blk_sel is a type mismatch:
    - err pulses the next cycle;
    - the partial block is discarded;
    - the mismatching word becomes word 0 of a new block with the new blk_sel.
- Block completion: the 4th accepted word moves the FSM to EMIT. In the EMIT cycle:
  - If blk_sel = 1: KEY <= asm and key_valid <= 1. next_round_enable stays 0 and OUT holds its value.
  - If blk_sel = 0 and key_valid = 1: OUT <= asm; next_round_enable = 1 on the following cycle, for exactly one cycle.
  - If blk_sel = 0 and key_valid = 0: the block is dropped, err pulses, and OUT is unchanged.
  - The FSM then returns to IDLE.
- Latency: from the posedge accepting word 3 to OUT/next_round_enable visible is 2 cycles (EMIT, then the registered output).
- Key stability: KEY changes only in EMIT of a key block. Data already in the pipeline is unaffected by the loader.
- flush:
  - In IDLE or COLLECT: count=0 and state=IDLE; no err.
  - In EMIT: the completing block still commits, because EMIT is not interruptible.
- Reset mid-block: the partial block is lost and key_valid is cleared, so the key must be reloaded.
- OUT holds between pulses; downstream qualifies it with next_round_enable only.
- err and next_round_enable never assert in the same cycle.

Optional Feature:
- Macro: AES_LOADER_BSWAP_EN.
- Defined: each accepted word is byte-reversed before assembly (in_word[7:0] becomes the most significant byte), for little-endian hosts. Applies to both plaintext and key words.
- Undefined: words are stored as received. All timing is identical in both cases.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W = 128;
  - AES_WORD_W = 32;
  - AES_WORDS_PER_BLK = 4;
  - loader FSM state enum (LD_IDLE, LD_COLLECT, LD_EMIT);
  - SEL_DATA/SEL_KEY constants.
- One natural sub-module: aes_word_packer. It holds the count, the assembly shift register and the optional byte swap, and outputs asm and word-4-accepted. The FSM, key register and output registers stay in the top module.

Test Plan:
- Key then data: key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c (in_sel=1), then plaintext 3243f6a8, 885a308d, 313198a2, e0370734.
  - Expect KEY = 2b7e1516_28aed2a6_abf71588_09cf4f3c and key_valid=1.
  - Expect OUT = 3243f6a8_885a308d_313198a2_e0370734 with a one-cycle next_round_enable 2 cycles after the last word.
- Data before any key: 4 plaintext words after reset. Expect err pulse, next_round_enable=0, OUT=0.
- Type mismatch: 2 data words, then a key word and 3 more key words.
  - Expect one err pulse.
  - Expect KEY = {key word, 3 key words} and no enable.
- Back-to-back with in_valid held high: 3 data blocks. Expect in_ready low exactly 1 cycle per block and enable pulses 5 cycles apart.
- flush and reset mid-block:
  - flush after 3 words, then 4 fresh words: OUT equals the fresh block, no err.
  - rst after 2 words: all outputs 0 and key_valid=0.
- AES_LOADER_BSWAP_EN defined: word 0x01020304. Expect OUT[127:96] = 0x04030201.
